load_store_unit: RTL
====================

Name: load_store_unit

Overview:
CPU-side initiator for the data port of the memory controller. Accepts one load/store request per transaction from the execute stage and drives the address/value/op-type port. Performs byte/halfword extraction, sign/zero extension, read-modify-write for sub-word stores, and splits word-boundary-crossing accesses into two word accesses.

Parameters:
MEM_LATENCY, 1, cycles from a read issue cycle until i_mem_val is valid (min 1).
ADDR_W, 32, address width; all address arithmetic wraps modulo 2^ADDR_W.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  reset, asynchronous, active-low.
i_req  input  1  request valid; accepted when i_req && o_ready.
i_we  input  1  0 = load, 1 = store.
i_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
i_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
i_addr  input  ADDR_W  byte address.
i_wdata  input  32  store data, right-aligned.
o_ready  output  1  high only in IDLE.
o_done  output  1  one-cycle completion pulse.
o_rdata  output  32  load result, held until the next load completes.
o_mem_en  output  1  memory access strobe.
o_mem_address  output  ADDR_W  word-aligned address (bits [1:0] = 0).
o_mem_val  output  32  write data.
o_mem_op_type  output  1  0 = read, 1 = write.
i_mem_val  input  32  read data from the memory controller.

Behaviour:
- Reset (i_rst = 0, asynchronous): state IDLE, o_ready = 1, o_done = 0, o_rdata = 0, o_mem_en = 0, o_mem_address = 0, o_mem_val = 0, o_mem_op_type = 0.
- All request inputs are captured at acceptance; later changes are ignored. i_req while busy is ignored, with no queuing.
- off = addr[1:0]. lo = addr & ~3. hi = lo + 4 (wraps). Little-endian byte lanes.
- Crossing: word with off != 0, or half with off == 3. Otherwise the access is single.
- FSM: IDLE -> RD_LO -> [RD_HI] -> [WR_LO -> [WR_HI]] -> DONE -> IDLE.
- Load path: RD_LO, then RD_HI if crossing, then DONE.
- Aligned word store: WR_LO -> DONE, with no read.
- Sub-word or crossing store: RD_LO, [RD_HI], WR_LO, [WR_HI], DONE.
- RD_x state:
  - o_mem_en = 1 and op_type = 0 in the first cycle only.
  - A counter waits MEM_LATENCY cycles, then i_mem_val is captured into a lo or hi buffer.
- WR_x state: one cycle, o_mem_en = 1, op_type = 1, o_mem_val = merged word.
- Load result:
  - {hi_buf, lo_buf} >> (8*off); hi_buf = 0 when the access is single.
  - Take the low 8/16/32 bits, extend per i_unsigned, register into o_rdata on entry to DONE.
- Store merge:
  - Data = i_wdata masked to size, << 8*off, into a 64-bit image.
  - Byte mask = (1/3/F) << off.
  - Masked bytes replace the corresponding bytes of {hi_buf, lo_buf}.
- DONE: o_done = 1 for one cycle, o_ready = 0, then IDLE. A new request is accepted the cycle after o_done.
- Latency from the acceptance edge (L = MEM_LATENCY), measured to the o_done cycle:
  - Aligned load: 2 + L.
  - Crossing load: 3 + 2L.
  - Aligned word store: 2.
  - Sub-word store: 3 + L.
  - Crossing store: 5 + 2L.
- o_mem_en is 0 outside issue cycles. o_mem_address and o_mem_op_type hold their last values when idle.
- Reset mid-operation: immediate return to IDLE and outputs to reset values. A completed WR_LO is not rolled back.
- Address 0xFFFFFFFF half access: hi = 0x00000000.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Adds output o_misaligned (1 bit, reset 0).
  - A crossing request goes IDLE -> DONE with no memory access.
  - o_misaligned = 1 together with o_done; o_rdata is unchanged.
- Undefined: port absent; crossing accesses are split as above.

Test Plan:
- Reset: hold i_rst = 0 mid-idle -> o_ready = 1, o_done = 0, o_rdata = 0, o_mem_en = 0.
- Aligned word load, L = 1:
  - Stimulus: 0x100, mem = 0xDEADBEEF.
  - Cycle 1: o_mem_en = 1, addr 0x100, op 0.
  - o_done at cycle 3, o_rdata = 0xDEADBEEF.
- Byte load 0x101, word 0x123480FF:
  - Signed -> 0xFFFFFF80.
  - Unsigned -> 0x00000080.
- Byte store 0xAB to 0x102, word 0x11223344 -> read 0x100, then write 0x100 = 0x11AB3344, then o_done.
- Crossing word load 0x0FE, @0xFC = 0xAABBCCDD, @0x100 = 0x11223344:
  - Reads 0xFC then 0x100; o_rdata = 0x3344AABB.
  - With MISALIGN_TRAP_EN: o_misaligned = 1 with o_done, o_mem_en never set.
- Crossing store 0xCAFEBABE to 0x0FF:
  - Writes @0xFC = 0xBEBBCCDD, @0x100 = 0x11CAFEBA.
  - Second run: i_rst = 0 the cycle after WR_LO -> o_mem_en = 0 immediately, @0x100 unchanged.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
// ---------------------------------------------------------------------------
// CPU-side initiator for the memory controller data port. Takes one
// load/store request at a time from the execute stage and turns it into
// word-aligned memory reads/writes. Handles byte/halfword lane extraction,
// sign/zero extension, read-modify-write for sub-word stores, and splits
// accesses that straddle a word boundary into a lo-word and a hi-word access.
//
// Optional feature (compile-time macro MISALIGN_TRAP_EN):
//   defined   -> adds o_misaligned; boundary-crossing requests complete at
//                once with o_misaligned = 1 and no memory traffic.
//   undefined -> crossing requests are split into two word accesses.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), async active-low reset
//   i_req/i_we/i_size/i_unsigned/i_addr/i_wdata   request from execute stage
//   o_ready               high only while idle (request accepted on i_req)
//   o_done                one-cycle completion pulse
//   o_rdata               load result, held until the next load completes
//   o_mem_en/o_mem_address/o_mem_val/o_mem_op_type   memory request port
//   i_mem_val             read data, valid MEM_LATENCY cycles after issue
//   o_misaligned          (MISALIGN_TRAP_EN only) trap flag, with o_done
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_ready,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [31:0]       o_mem_val,
  output logic              o_mem_op_type,
`ifdef MISALIGN_TRAP_EN
  output logic              o_misaligned,
`endif
  input  logic [31:0]       i_mem_val
);

  localparam int CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [ADDR_W-1:0] WORD_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_WR_LO = 3'd3,
    ST_WR_HI = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Byte-lane mask of the access within the 8-byte {hi, lo} window.
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] m;
    case (size)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << off;
  endfunction

  // Widen a per-byte mask into a per-bit mask.
  function automatic logic [63:0] expand_mask(input logic [7:0] m);
    logic [63:0] e;
    for (int i = 0; i < 8; i++) begin
      e[8*i +: 8] = {8{m[i]}};
    end
    return e;
  endfunction

  // Word with a non-zero offset, or a half in the last lane, spans two words.
  function automatic logic is_cross(input logic [1:0] size, input logic [1:0] off);
    return (size[1] && (off != 2'b00)) || ((size == 2'b01) && (off == 2'b11));
  endfunction

  // Store data trimmed to its size and moved into its byte lanes.
  function automatic logic [63:0] store_image(input logic [31:0] wdata, input logic [1:0] size,
                                              input logic [1:0] off);
    logic [31:0] d;
    case (size)
      2'b00:   d = {24'h000000, wdata[7:0]};
      2'b01:   d = {16'h0000, wdata[15:0]};
      default: d = wdata;
    endcase
    return {32'h00000000, d} << {off, 3'b000};
  endfunction

  // Shift the addressed bytes down, then sign- or zero-extend them.
  function automatic logic [31:0] extract_load(input logic [63:0] img, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    logic [31:0] r;
    sh = img >> {off, 3'b000};
    case (size)
      2'b00:   r = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   r = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
      default: r = sh[31:0];
    endcase
    return r;
  endfunction

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [31:0]       lo_buf_r;
  logic [31:0]       hi_buf_r;
  logic [ADDR_W-1:0] lo_addr_r;
  logic [ADDR_W-1:0] hi_addr_r;
  logic [1:0]        off_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic              we_r;
  logic              cross_r;
  logic [31:0]       wdata_r;

  logic              lat_hit_s;
  logic [31:0]       lo_cap_s;
  logic [31:0]       hi_cap_s;
  logic [63:0]       img_s;
  logic [63:0]       emask_s;
  logic [63:0]       merged_s;
  logic [31:0]       load_res_s;
  logic [1:0]        acc_off_s;
  logic [ADDR_W-1:0] acc_lo_s;
  logic              acc_cross_s;
  logic              acc_wstore_s;
  logic              trap_s;

  // Data-path: buffers with the word arriving this cycle folded in, so the
  // load result and the merged store word are ready on the capture edge.
  always_comb begin
    lat_hit_s = (cnt_r == LAT_C);
    if ((state_r == ST_RD_LO) && lat_hit_s) lo_cap_s = i_mem_val;
    else                                    lo_cap_s = lo_buf_r;
    if ((state_r == ST_RD_HI) && lat_hit_s) hi_cap_s = i_mem_val;
    else                                    hi_cap_s = hi_buf_r;
    if (cross_r) img_s = {hi_cap_s, lo_cap_s};
    else         img_s = {32'h00000000, lo_cap_s};
    emask_s    = expand_mask(byte_mask(size_r, off_r));
    merged_s   = (img_s & ~emask_s) | (store_image(wdata_r, size_r, off_r) & emask_s);
    load_res_s = extract_load(img_s, off_r, size_r, uns_r);
  end

  // Request decode used on the acceptance edge.
  always_comb begin
    acc_off_s    = i_addr[1:0];
    acc_lo_s     = {i_addr[ADDR_W-1:2], 2'b00};
    acc_cross_s  = is_cross(i_size, acc_off_s);
    acc_wstore_s = i_we && i_size[1] && (acc_off_s == 2'b00);
`ifdef MISALIGN_TRAP_EN
    trap_s = acc_cross_s;
`else
    trap_s = 1'b0;
`endif
  end

  // Control FSM with registered memory-port and handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      lo_buf_r      <= 32'h00000000;
      hi_buf_r      <= 32'h00000000;
      lo_addr_r     <= {ADDR_W{1'b0}};
      hi_addr_r     <= {ADDR_W{1'b0}};
      off_r         <= 2'b00;
      size_r        <= 2'b00;
      uns_r         <= 1'b0;
      we_r          <= 1'b0;
      cross_r       <= 1'b0;
      wdata_r       <= 32'h00000000;
      o_ready       <= 1'b1;
      o_done        <= 1'b0;
      o_rdata       <= 32'h00000000;
      o_mem_en      <= 1'b0;
      o_mem_address <= {ADDR_W{1'b0}};
      o_mem_val     <= 32'h00000000;
      o_mem_op_type <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      o_misaligned  <= 1'b0;
`endif
    end else begin
      // The strobe is only ever high for the single issue cycle.
      o_mem_en <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          o_done <= 1'b0;
          if (i_req) begin
            lo_addr_r <= acc_lo_s;
            hi_addr_r <= acc_lo_s + WORD_STEP;
            off_r     <= acc_off_s;
            size_r    <= i_size;
            uns_r     <= i_unsigned;
            we_r      <= i_we;
            cross_r   <= acc_cross_s;
            wdata_r   <= i_wdata;
            lo_buf_r  <= 32'h00000000;
            hi_buf_r  <= 32'h00000000;
            cnt_r     <= {CNT_W{1'b0}};
            o_ready   <= 1'b0;
            if (trap_s) begin
              state_r <= ST_DONE;
              o_done  <= 1'b1;
`ifdef MISALIGN_TRAP_EN
              o_misaligned <= 1'b1;
`endif
            end else if (acc_wstore_s) begin
              // Full aligned word overwrites everything: no read needed.
              state_r       <= ST_WR_LO;
              o_mem_en      <= 1'b1;
              o_mem_op_type <= 1'b1;
              o_mem_address <= acc_lo_s;
              o_mem_val     <= i_wdata;
            end else begin
              state_r       <= ST_RD_LO;
              o_mem_en      <= 1'b1;
              o_mem_op_type <= 1'b0;
              o_mem_address <= acc_lo_s;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD_LO: begin
          if (lat_hit_s) begin
            lo_buf_r <= i_mem_val;
            cnt_r    <= {CNT_W{1'b0}};
            if (cross_r) begin
              state_r       <= ST_RD_HI;
              o_mem_en      <= 1'b1;
              o_mem_op_type <= 1'b0;
              o_mem_address <= hi_addr_r;
            end else if (we_r) begin
              state_r       <= ST_WR_LO;
              o_mem_en      <= 1'b1;
              o_mem_op_type <= 1'b1;
              o_mem_address <= lo_addr_r;
              o_mem_val     <= merged_s[31:0];
            end else begin
              state_r <= ST_DONE;
              o_done  <= 1'b1;
              o_rdata <= load_res_s;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_RD_HI: begin
          if (lat_hit_s) begin
            hi_buf_r <= i_mem_val;
            cnt_r    <= {CNT_W{1'b0}};
            if (we_r) begin
              state_r       <= ST_WR_LO;
              o_mem_en      <= 1'b1;
              o_mem_op_type <= 1'b1;
              o_mem_address <= lo_addr_r;
              o_mem_val     <= merged_s[31:0];
            end else begin
              state_r <= ST_DONE;
              o_done  <= 1'b1;
              o_rdata <= load_res_s;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WR_LO: begin
          if (cross_r) begin
            state_r       <= ST_WR_HI;
            o_mem_en      <= 1'b1;
            o_mem_op_type <= 1'b1;
            o_mem_address <= hi_addr_r;
            o_mem_val     <= merged_s[63:32];
          end else begin
            state_r <= ST_DONE;
            o_done  <= 1'b1;
          end
        end
        ST_WR_HI: begin
          state_r <= ST_DONE;
          o_done  <= 1'b1;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          o_done  <= 1'b0;
          o_ready <= 1'b1;
`ifdef MISALIGN_TRAP_EN
          o_misaligned <= 1'b0;
`endif
        end
        default: begin
          state_r <= ST_IDLE;
          o_done  <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
